// File: rtl/video_timing_gen_pkg.sv
// Shared timing constants and per-axis timing-set types for the video timing generator.
package video_timing_pkg;

  // Default raster: 640x480 @ 60 Hz (pixel clock 25.175 MHz).
  localparam int H_BLANK  = 640;
  localparam int H_SYNC   = 656;
  localparam int H_SYNC_E = 752;
  localparam int H_TOTAL  = 800;

  localparam int V_BLANK  = 480;
  localparam int V_SYNC   = 490;
  localparam int V_SYNC_E = 492;
  localparam int V_TOTAL  = 525;

  localparam int DEF_WH = 11;
  localparam int DEF_WV = 10;

  // One timing set per axis, sized for the default field widths.
  typedef struct packed {
    logic [DEF_WH-1:0] blank;
    logic [DEF_WH-1:0] sync;
    logic [DEF_WH-1:0] sync_e;
    logic [DEF_WH-1:0] total;
  } h_timing_t;

  typedef struct packed {
    logic [DEF_WV-1:0] blank;
    logic [DEF_WV-1:0] sync;
    logic [DEF_WV-1:0] sync_e;
    logic [DEF_WV-1:0] total;
  } v_timing_t;

endpackage

// File: rtl/video_timing_gen_if.sv
// Configuration handshake bus: the source (master) presents a full timing set with
// cfg_valid and holds it; the generator (slave) answers with a one-cycle cfg_ack at
// the frame boundary where the set is taken. valid/ready semantics: a transfer happens
// only on the cycle cfg_valid is high at a frame-end edge; cfg_ack reports it one cycle later.
interface video_timing_gen_if #(
  parameter int WH = 11,
  parameter int WV = 10
);
  logic          cfg_valid;
  logic          cfg_ack;
  logic [WH-1:0] cfg_h_blank;
  logic [WH-1:0] cfg_h_sync;
  logic [WH-1:0] cfg_h_sync_e;
  logic [WH-1:0] cfg_h_total;
  logic [WV-1:0] cfg_v_blank;
  logic [WV-1:0] cfg_v_sync;
  logic [WV-1:0] cfg_v_sync_e;
  logic [WV-1:0] cfg_v_total;

  modport master (
    output cfg_valid, cfg_h_blank, cfg_h_sync, cfg_h_sync_e, cfg_h_total,
           cfg_v_blank, cfg_v_sync, cfg_v_sync_e, cfg_v_total,
    input  cfg_ack
  );

  modport slave (
    input  cfg_valid, cfg_h_blank, cfg_h_sync, cfg_h_sync_e, cfg_h_total,
           cfg_v_blank, cfg_v_sync, cfg_v_sync_e, cfg_v_total,
    output cfg_ack
  );
endinterface

// File: rtl/video_timing_gen_axis.sv
// One raster axis: wrapping counter, shadow timing registers, blank and sync decode.
module timing_axis
  import video_timing_pkg::*;
#(
  parameter int W          = 11,
  parameter bit SYNC_POL   = 1'b0,
  parameter int DEF_BLANK  = H_BLANK,
  parameter int DEF_SYNC   = H_SYNC,
  parameter int DEF_SYNC_E = H_SYNC_E,
  parameter int DEF_TOTAL  = H_TOTAL
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] new_blank,
  input  logic [W-1:0] new_sync,
  input  logic [W-1:0] new_sync_e,
  input  logic [W-1:0] new_total,
  output logic [W-1:0] cnt,
  output logic         last,
  output logic         blank,
  output logic         sync
);

  typedef struct packed {
    logic [W-1:0] blank;
    logic [W-1:0] sync;
    logic [W-1:0] sync_e;
    logic [W-1:0] total;
  } axis_cfg_t;

  localparam axis_cfg_t DEFAULTS = '{
    blank:  W'(DEF_BLANK),
    sync:   W'(DEF_SYNC),
    sync_e: W'(DEF_SYNC_E),
    total:  W'(DEF_TOTAL)
  };

  axis_cfg_t shadow;

  // total-1 is taken in field width, so total==0 wraps at the full 2^W range.
  assign last  = (cnt == shadow.total - W'(1));
  assign blank = (cnt >= shadow.blank);
  assign sync  = ((cnt >= shadow.sync) && (cnt < shadow.sync_e)) ? SYNC_POL : !SYNC_POL;

  // Position counter: advance on inc, wrap to 0 after total-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= last ? '0 : cnt + W'(1);
    end
  end

  // Shadow timing set: replaced only when the top signals a frame-aligned load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= DEFAULTS;
    end else if (load) begin
      shadow <= '{blank: new_blank, sync: new_sync, sync_e: new_sync_e, total: new_total};
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Two-axis video timing generator with frame-aligned configuration handshake.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int WH        = 11,
  parameter int WV        = 10,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  video_timing_gen_if.slave cfg,
  output logic [WH-1:0]     x,
  output logic [WV-1:0]     y,
  output logic              active,
  output logic              hblank,
  output logic              vblank,
  output logic              hsync,
  output logic              vsync,
  output logic              line_start,
  output logic              frame_start
);

  logic h_last;
  logic v_last;
  logic frame_end;
  logic load;

  // Both axes take the new set on the same edge the counters wrap, so the wrap
  // itself still uses the old totals and the new set starts at pixel (0,0).
  assign frame_end = en & h_last & v_last;
  assign load      = frame_end & cfg.cfg_valid;

  timing_axis #(
    .W(WH), .SYNC_POL(HSYNC_POL),
    .DEF_BLANK(H_BLANK), .DEF_SYNC(H_SYNC), .DEF_SYNC_E(H_SYNC_E), .DEF_TOTAL(H_TOTAL)
  ) u_h (
    .clk(clk), .rst(rst), .inc(en), .load(load),
    .new_blank(cfg.cfg_h_blank), .new_sync(cfg.cfg_h_sync),
    .new_sync_e(cfg.cfg_h_sync_e), .new_total(cfg.cfg_h_total),
    .cnt(x), .last(h_last), .blank(hblank), .sync(hsync)
  );

  timing_axis #(
    .W(WV), .SYNC_POL(VSYNC_POL),
    .DEF_BLANK(V_BLANK), .DEF_SYNC(V_SYNC), .DEF_SYNC_E(V_SYNC_E), .DEF_TOTAL(V_TOTAL)
  ) u_v (
    .clk(clk), .rst(rst), .inc(en & h_last), .load(load),
    .new_blank(cfg.cfg_v_blank), .new_sync(cfg.cfg_v_sync),
    .new_sync_e(cfg.cfg_v_sync_e), .new_total(cfg.cfg_v_total),
    .cnt(y), .last(v_last), .blank(vblank), .sync(vsync)
  );

  // Acknowledge pulse: high for exactly the cycle after the shadow load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg.cfg_ack <= 1'b0;
    end else begin
      cfg.cfg_ack <= load;
    end
  end

  assign active      = ~hblank & ~vblank;
  // Strobes are held off during reset even though x/y already read zero.
  assign line_start  = en & ~rst & (x == '0);
  assign frame_start = line_start & (y == '0);

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a full-size instance (11/10 bits, active-low syncs) and a
// small instance (4/4 bits, active-high syncs) run side by side against a raster model.
module tb_video_timing_gen;
  import video_timing_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic en;
  always #5 clk = ~clk;

  video_timing_gen_if #(.WH(11), .WV(10)) cfg_a ();
  video_timing_gen_if #(.WH(4),  .WV(4))  cfg_b ();

  logic [10:0] xa;
  logic [9:0]  ya;
  logic active_a, hblank_a, vblank_a, hsync_a, vsync_a, line_start_a, frame_start_a;
  logic [3:0]  xb;
  logic [3:0]  yb;
  logic active_b, hblank_b, vblank_b, hsync_b, vsync_b, line_start_b, frame_start_b;

  video_timing_gen #(.WH(11), .WV(10), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .cfg(cfg_a.slave),
    .x(xa), .y(ya), .active(active_a), .hblank(hblank_a), .vblank(vblank_a),
    .hsync(hsync_a), .vsync(vsync_a), .line_start(line_start_a), .frame_start(frame_start_a)
  );

  video_timing_gen #(.WH(4), .WV(4), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .cfg(cfg_b.slave),
    .x(xb), .y(yb), .active(active_b), .hblank(hblank_b), .vblank(vblank_b),
    .hsync(hsync_b), .vsync(vsync_b), .line_start(line_start_b), .frame_start(frame_start_b)
  );

  // ---------------- reference model ----------------
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  int wh[2], wv[2];
  bit pol[2];
  int mx[2], my[2];
  int hb[2], hs[2], hse[2], ht[2];
  int vb[2], vs[2], vse[2], vt[2];
  bit mack[2];
  bit cv[2];
  int cfg_v[2][8];

  int ls_a_prev, ls_a_period, ls_b_prev, ls_b_period, fs_b_prev, fs_b_period;

  function automatic void model_reset(int d);
    mx[d] = 0; my[d] = 0; mack[d] = 1'b0;
    hb[d] = H_BLANK % (1 << wh[d]); hs[d] = H_SYNC % (1 << wh[d]);
    hse[d] = H_SYNC_E % (1 << wh[d]); ht[d] = H_TOTAL % (1 << wh[d]);
    vb[d] = V_BLANK % (1 << wv[d]); vs[d] = V_SYNC % (1 << wv[d]);
    vse[d] = V_SYNC_E % (1 << wv[d]); vt[d] = V_TOTAL % (1 << wv[d]);
  endfunction

  // Advance one enabled pixel; a frame end with a pending set swaps it in.
  function automatic void model_step(int d, bit e);
    int hp, vp;
    bit ld;
    if (!e) begin
      mack[d] = 1'b0;
      return;
    end
    hp = (ht[d] == 0) ? (1 << wh[d]) : ht[d];
    vp = (vt[d] == 0) ? (1 << wv[d]) : vt[d];
    ld = (mx[d] == hp - 1) && (my[d] == vp - 1) && cv[d];
    if (mx[d] == hp - 1) begin
      mx[d] = 0;
      my[d] = (my[d] == vp - 1) ? 0 : my[d] + 1;
    end else begin
      mx[d] = mx[d] + 1;
    end
    if (ld) begin
      hb[d]  = cfg_v[d][0] % (1 << wh[d]); hs[d]  = cfg_v[d][1] % (1 << wh[d]);
      hse[d] = cfg_v[d][2] % (1 << wh[d]); ht[d]  = cfg_v[d][3] % (1 << wh[d]);
      vb[d]  = cfg_v[d][4] % (1 << wv[d]); vs[d]  = cfg_v[d][5] % (1 << wv[d]);
      vse[d] = cfg_v[d][6] % (1 << wv[d]); vt[d]  = cfg_v[d][7] % (1 << wv[d]);
    end
    mack[d] = ld;
  endfunction

  function automatic logic [39:0] model_out(int d, bit e, bit r);
    logic hbl, vbl, hsy, vsy, ls, fs;
    hbl = (mx[d] >= hb[d]);
    vbl = (my[d] >= vb[d]);
    hsy = (mx[d] >= hs[d] && mx[d] < hse[d]) ? pol[d] : !pol[d];
    vsy = (my[d] >= vs[d] && my[d] < vse[d]) ? pol[d] : !pol[d];
    ls  = e && !r && (mx[d] == 0);
    fs  = ls && (my[d] == 0);
    return {16'(mx[d]), 16'(my[d]), !hbl && !vbl, hbl, vbl, hsy, vsy, ls, fs, mack[d]};
  endfunction

  function automatic logic [39:0] dut_out(int d);
    if (d == 0)
      return {16'(xa), 16'(ya), active_a, hblank_a, vblank_a, hsync_a, vsync_a,
              line_start_a, frame_start_a, cfg_a.cfg_ack};
    return {16'(xb), 16'(yb), active_b, hblank_b, vblank_b, hsync_b, vsync_b,
            line_start_b, frame_start_b, cfg_b.cfg_ack};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check_all(bit e, bit r);
    logic [39:0] act, exp;
    for (int d = 0; d < 2; d++) begin
      act = dut_out(d);
      exp = model_out(d, e, r);
      n_vec++;
      assert (act === exp) else begin
        n_err++;
        $error("FAIL raster dut%0d cyc=%0d observed=%h expected=%h", d, cyc, act, exp);
      end
    end
  endtask

  task automatic chk(string tag, int act, int exp);
    n_vec++;
    assert (act === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_cfg();
    cfg_a.cfg_valid    = cv[0];
    cfg_a.cfg_h_blank  = 11'(cfg_v[0][0]); cfg_a.cfg_h_sync   = 11'(cfg_v[0][1]);
    cfg_a.cfg_h_sync_e = 11'(cfg_v[0][2]); cfg_a.cfg_h_total  = 11'(cfg_v[0][3]);
    cfg_a.cfg_v_blank  = 10'(cfg_v[0][4]); cfg_a.cfg_v_sync   = 10'(cfg_v[0][5]);
    cfg_a.cfg_v_sync_e = 10'(cfg_v[0][6]); cfg_a.cfg_v_total  = 10'(cfg_v[0][7]);
    cfg_b.cfg_valid    = cv[1];
    cfg_b.cfg_h_blank  = 4'(cfg_v[1][0]); cfg_b.cfg_h_sync   = 4'(cfg_v[1][1]);
    cfg_b.cfg_h_sync_e = 4'(cfg_v[1][2]); cfg_b.cfg_h_total  = 4'(cfg_v[1][3]);
    cfg_b.cfg_v_blank  = 4'(cfg_v[1][4]); cfg_b.cfg_v_sync   = 4'(cfg_v[1][5]);
    cfg_b.cfg_v_sync_e = 4'(cfg_v[1][6]); cfg_b.cfg_v_total  = 4'(cfg_v[1][7]);
  endtask

  task automatic reset_meas();
    ls_a_prev = -1; ls_a_period = -1;
    ls_b_prev = -1; ls_b_period = -1;
    fs_b_prev = -1; fs_b_period = -1;
  endtask

  // One pixel clock: drive at negedge, check, then step the model on the posedge.
  task automatic cycle(bit e);
    @(negedge clk);
    en = e;
    drive_cfg();
    #1;
    cyc++;
    check_all(e, 1'b0);
    if (line_start_a) begin
      if (ls_a_prev >= 0) ls_a_period = cyc - ls_a_prev;
      ls_a_prev = cyc;
    end
    if (line_start_b) begin
      if (ls_b_prev >= 0) ls_b_period = cyc - ls_b_prev;
      ls_b_prev = cyc;
    end
    if (frame_start_b) begin
      if (fs_b_prev >= 0) fs_b_period = cyc - fs_b_prev;
      fs_b_prev = cyc;
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      model_step(d, e);
      if (mack[d]) cv[d] = 1'b0;
    end
  endtask

  task automatic run(int n, int mode);
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       cycle(1'b1);
        1:       cycle(i[0] == 1'b0);
        default: cycle(1'(($urandom_range(0, 3) != 0)));
      endcase
    end
  endtask

  // Offer a timing set to dut_b and wait (bounded) for its acknowledge.
  task automatic load_b(int s0, int s1, int s2, int s3, int s4, int s5, int s6, int s7);
    int n;
    cfg_v[1] = '{s0, s1, s2, s3, s4, s5, s6, s7};
    cv[1] = 1'b1;
    n = 0;
    while (cv[1] && n < 2000) begin
      cycle(1'($urandom_range(0, 1)));
      n++;
    end
    chk("b_cfg_ack_seen", int'(cv[1]), 0);
  endtask

  // Asynchronous reset asserted mid-cycle while en is high.
  task automatic mid_reset();
    #2;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) model_reset(d);
    check_all(en, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_step(d, en);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    wh = '{11, 4}; wv = '{10, 4}; pol = '{1'b0, 1'b1};
    cv = '{1'b0, 1'b0};
    cfg_v[0] = '{0, 0, 0, 0, 0, 0, 0, 0};
    cfg_v[1] = '{0, 0, 0, 0, 0, 0, 0, 0};
    rst = 1'b1;
    en  = 1'b0;
    drive_cfg();
    for (int d = 0; d < 2; d++) model_reset(d);
    #1;
    check_all(1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);

    // Default timing, en held high.
    reset_meas();
    run(1700, 0);
    chk("a_line_period_en1", ls_a_period, 800);
    chk("b_frame_period_default", fs_b_period, 208);

    // en toggling every cycle doubles every period.
    reset_meas();
    run(3300, 1);
    chk("a_line_period_en_toggle", ls_a_period, 1600);
    chk("b_frame_period_en_toggle", fs_b_period, 416);

    // dut_a gets a pending set that cannot land mid-frame; dut_b swaps to 12x8.
    cfg_v[0] = '{100, 110, 120, 130, 10, 11, 12, 13};
    cv[0] = 1'b1;
    load_b(8, 9, 10, 12, 4, 5, 6, 8);
    reset_meas();
    run(300, 0);
    chk("b_line_period_12", ls_b_period, 12);
    chk("b_frame_period_96", fs_b_period, 96);

    // h_total=0 counts the full 4-bit range.
    load_b(4, 8, 12, 0, 4, 5, 6, 8);
    reset_meas();
    run(400, 0);
    chk("b_line_period_total0", ls_b_period, 16);
    chk("b_frame_period_total0", fs_b_period, 128);

    // h_total=2: x alternates 0,1.
    load_b(1, 1, 2, 2, 4, 5, 6, 8);
    reset_meas();
    run(100, 2);
    run(100, 0);
    chk("b_line_period_total2", ls_b_period, 2);
    chk("b_frame_period_total2", fs_b_period, 16);

    // Reset in the middle of a dut_a line; shadow sets return to defaults.
    cv[0] = 1'b0;
    n = 0;
    while (mx[0] != 300 && n < 1000) begin
      cycle(1'b1);
      n++;
    end
    chk("a_reached_x300", mx[0], 300);
    mid_reset();
    reset_meas();
    run(1700, 0);
    chk("a_line_period_after_rst", ls_a_period, 800);
    chk("b_frame_period_after_rst", fs_b_period, 208);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
